// File: rtl/xfer_load_ctrl.sv
// xfer_load_ctrl: sequences and arbitrates the active-low load strobes of the
// 16-bit transfer register for three requesters. The requesters are a wide
// load (AddrBus/XferBus), a MainBus byte pair, and a single MainBus byte.
//
// Ports:
//   clk, rst           - clock (rising edge), async active-high reset
//   req_wide/wide_src  - wide load request and its source (0=AddrBus, 1=XferBus)
//   req_pair           - low-then-high byte pair load request from MainBus
//   req_byte/byte_hi   - single byte load request and byte select
//   main_valid         - MainBus carries a valid byte this cycle
//   flush              - synchronous pipeline flush, overrides everything
//   reg_xfer_load      - active-low 16-bit load strobe
//   reg_main_low_load  - active-low low-byte load strobe
//   reg_main_high_load - active-low high-byte load strobe
//   xfer_src_sel       - registered wide source select
//   ack                - one-cycle completion pulse
//   busy               - controller not idle
//   timeout_err        - sticky MainBus timeout flag, cleared by next grant
module xfer_load_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned TO_W           = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic req_wide,
  input  logic wide_src,
  input  logic req_pair,
  input  logic req_byte,
  input  logic byte_hi,
  input  logic main_valid,
  input  logic flush,
  output logic reg_xfer_load,
  output logic reg_main_low_load,
  output logic reg_main_high_load,
  output logic xfer_src_sel,
  output logic ack,
  output logic busy,
  output logic timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WIDE    = 3'd1,
    S_PAIR_LO = 3'd2,
    S_PAIR_HI = 3'd3,
    S_BYTE    = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic              src_q, src_d;
  logic              hi_q, hi_d;
  logic              err_q, err_d;
  logic              timed_out;

  assign timed_out    = (cnt_q == TO_W'(TIMEOUT_CYCLES));
  assign xfer_src_sel = src_q;
  assign timeout_err  = err_q;
  assign busy         = (state_q != S_IDLE);

  // State and context registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      src_q   <= 1'b0;
      hi_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      hi_q    <= hi_d;
      err_q   <= err_d;
    end
  end

  // Next state and strobes. The strobes are decoded from the state flop and
  // main_valid, so a reset drops them without waiting for a clock edge.
  always_comb begin
    state_d            = state_q;
    cnt_d              = cnt_q;
    src_d              = src_q;
    hi_d               = hi_q;
    err_d              = err_q;
    reg_xfer_load      = 1'b1;
    reg_main_low_load  = 1'b1;
    reg_main_high_load = 1'b1;
    ack                = 1'b0;

    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_d = '0;
          if (req_wide) begin
            src_d   = wide_src;
            err_d   = 1'b0;
            state_d = S_WIDE;
          end else if (req_pair) begin
            err_d   = 1'b0;
            state_d = S_PAIR_LO;
          end else if (req_byte) begin
            hi_d    = byte_hi;
            err_d   = 1'b0;
            state_d = S_BYTE;
          end
        end

        S_WIDE: begin
          reg_xfer_load = 1'b0;
          ack           = 1'b1;
          state_d       = S_IDLE;
        end

        S_PAIR_LO: begin
          if (main_valid) begin
            reg_main_low_load = 1'b0;
            cnt_d             = '0;
            state_d           = S_PAIR_HI;
          end else if (timed_out) begin
            // An aborted pair leaves nothing half-loaded to undo here.
            err_d   = 1'b1;
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + TO_W'(1);
          end
        end

        S_PAIR_HI: begin
          if (main_valid) begin
            reg_main_high_load = 1'b0;
            ack                = 1'b1;
            cnt_d              = '0;
            state_d            = S_IDLE;
          end else if (timed_out) begin
            // Low byte already captured stays loaded.
            err_d   = 1'b1;
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + TO_W'(1);
          end
        end

        S_BYTE: begin
          if (main_valid) begin
            if (hi_q) reg_main_high_load = 1'b0;
            else      reg_main_low_load  = 1'b0;
            ack     = 1'b1;
            cnt_d   = '0;
            state_d = S_IDLE;
          end else if (timed_out) begin
            err_d   = 1'b1;
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + TO_W'(1);
          end
        end

        default: begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xfer_load_ctrl.sv
// Testbench for xfer_load_ctrl: per-cycle vector table through a scoreboard
// queue, plus a hand-written asynchronous reset sequence.
module tb_xfer_load_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic req_wide, wide_src, req_pair, req_byte, byte_hi, main_valid, flush;
  logic reg_xfer_load, reg_main_low_load, reg_main_high_load;
  logic xfer_src_sel, ack, busy, timeout_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  xfer_load_ctrl #(.TIMEOUT_CYCLES(16), .TO_W(5)) dut (
    .clk(clk), .rst(rst),
    .req_wide(req_wide), .wide_src(wide_src), .req_pair(req_pair),
    .req_byte(req_byte), .byte_hi(byte_hi), .main_valid(main_valid),
    .flush(flush),
    .reg_xfer_load(reg_xfer_load), .reg_main_low_load(reg_main_low_load),
    .reg_main_high_load(reg_main_high_load), .xfer_src_sel(xfer_src_sel),
    .ack(ack), .busy(busy), .timeout_err(timeout_err)
  );

  // inputs: {req_wide, wide_src, req_pair, req_byte, byte_hi, main_valid, flush}
  // expect: {xfer_load, low_load, high_load, src_sel, ack, busy, timeout_err}
  typedef struct {
    logic [6:0] in;
    logic [6:0] exp;
  } vec_t;

  vec_t       vecs[$];
  logic [6:0] sb[$];

  task automatic add(input logic [6:0] i, input logic [6:0] e, input int n);
    vec_t v;
    v.in  = i;
    v.exp = e;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  task automatic drive(input logic [6:0] i);
    {req_wide, wide_src, req_pair, req_byte, byte_hi, main_valid, flush} = i;
  endtask

  function automatic logic [6:0] outs();
    return {reg_xfer_load, reg_main_low_load, reg_main_high_load,
            xfer_src_sel, ack, busy, timeout_err};
  endfunction

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (xl,ll,hl,src,ack,busy,err)", name, act, exp);
    end
  endtask

  initial begin
    logic [6:0] e;
    rst = 1'b1;
    drive(7'b0);

    // Wide with XferBus source, served in one cycle.
    add(7'b1100000, 7'b1110000, 1);
    add(7'b1100000, 7'b0111110, 1);
    add(7'b0000000, 7'b1111000, 1);
    // Pair: valid after 3 waits, then after 2 waits.
    add(7'b0010000, 7'b1111000, 1);
    add(7'b0010000, 7'b1111010, 3);
    add(7'b0010010, 7'b1011010, 1);
    add(7'b0010000, 7'b1111010, 2);
    add(7'b0010010, 7'b1101110, 1);
    add(7'b0000000, 7'b1111000, 1);
    // All three requesting: wide, then pair, then high byte.
    add(7'b1011000, 7'b1111000, 1);
    add(7'b1011000, 7'b0110110, 1);
    add(7'b0011000, 7'b1110000, 1);
    add(7'b0011010, 7'b1010010, 1);
    add(7'b0011010, 7'b1100110, 1);
    add(7'b0001100, 7'b1110000, 1);
    add(7'b0001110, 7'b1100110, 1);
    add(7'b0000000, 7'b1110000, 1);
    // Byte timeout: 17 waiting cycles, error set, no ack; next grant clears it.
    add(7'b0001100, 7'b1110000, 1);
    add(7'b0001100, 7'b1110010, 17);
    add(7'b0000000, 7'b1110001, 1);
    add(7'b0010000, 7'b1110001, 1);
    add(7'b0010010, 7'b1010010, 1);
    // Flush in PAIR_HI with main_valid: no strobe, no ack.
    add(7'b0010011, 7'b1110010, 1);
    add(7'b0000000, 7'b1110000, 1);
    // main_valid on the timeout cycle wins.
    add(7'b0001000, 7'b1110000, 1);
    add(7'b0001000, 7'b1110010, 16);
    add(7'b0001010, 7'b1010110, 1);
    add(7'b0000000, 7'b1110000, 1);
    // Flush in WIDE suppresses strobe and ack; flush in IDLE blocks grant.
    add(7'b1100000, 7'b1110000, 1);
    add(7'b1100001, 7'b1111010, 1);
    add(7'b0000000, 7'b1111000, 1);
    add(7'b0010001, 7'b1111000, 1);
    add(7'b0000000, 7'b1111000, 1);

    #3;
    chk("reset_values", outs(), 7'b1110000);
    #9 rst = 1'b0;

    for (int n = 0; n < vecs.size(); n++) begin
      @(posedge clk);
      #1;
      drive(vecs[n].in);
      sb.push_back(vecs[n].exp);
      @(negedge clk);
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty at vector %0d", n);
      end else begin
        e = sb.pop_front();
        chk($sformatf("vec%0d", n), outs(), e);
      end
    end

    // Asynchronous reset in the middle of PAIR_LO with main_valid high.
    @(posedge clk); #1;
    drive(7'b0010000);
    @(posedge clk); #1;
    drive(7'b0000010);
    #1 chk("pair_lo_before_rst", outs(), 7'b1011010);
    #1 rst = 1'b1;
    #1 chk("async_rst_mid_pair", outs(), 7'b1110000);
    drive(7'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_rst", outs(), 7'b1110000);

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d entries, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
